// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
// Cleans up the two raw vehicle-loop detector inputs (Academic Ave = A,
// Bravado Blvd = B) before they reach the intersection light controller.
// Each approach is synchronised, debounced (DEBOUNCE_CYCLES qualifying
// samples) and gap-bridged (presence held HOLD_CYCLES after the loop drops).
//
// Optional feature macro: TRAFFIC_COUNT_EN
//   defined   -> per-approach saturating vehicle counters with count_clr
//   undefined -> count_A/count_B tied to 0, count_clr ignored
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   raw_A/B    asynchronous loop-detector inputs
//   count_clr  synchronous clear of both counters
//   traffic_A/B conditioned presence (registered)
//   count_A/B  saturating vehicle counts (CNT_W bits)

// Per-approach synchroniser + presence FSM.
module tsc_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_traffic,
  output logic o_qualify   // high on the edge that moves QUALIFY->PRESENT
);
  typedef enum logic [1:0] {S_IDLE, S_QUALIFY, S_PRESENT, S_HOLD} state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

  logic       r_sync1, r_sync2;
  state_t     r_state;
  logic [7:0] r_timer;
  logic       r_traffic;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Presence is registered together with the state so the output never
  // glitches on a multi-bit state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= 8'd0;
      r_traffic <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_sync2) begin
            r_state <= S_QUALIFY;
            r_timer <= 8'd1;
          end
        end
        S_QUALIFY: begin
          if (!r_sync2) begin
            r_state <= S_IDLE;
            r_timer <= 8'd0;
          end else if (r_timer == DEB_LAST) begin
            r_state   <= S_PRESENT;
            r_traffic <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_PRESENT: begin
          if (!r_sync2) begin
            r_state <= S_HOLD;
            r_timer <= 8'd1;
          end
        end
        S_HOLD: begin
          // Retrigger inside the hold window: same vehicle stream, no recount.
          if (r_sync2) begin
            r_state <= S_PRESENT;
            r_timer <= 8'd0;
          end else if (r_timer == HOLD_LAST) begin
            r_state   <= S_IDLE;
            r_timer   <= 8'd0;
            r_traffic <= 1'b0;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_timer   <= 8'd0;
          r_traffic <= 1'b0;
        end
      endcase
    end
  end

  assign o_traffic = r_traffic;
  assign o_qualify = (r_state == S_QUALIFY) && r_sync2 && (r_timer == DEB_LAST);
endmodule

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_A,
  input  logic             raw_B,
  input  logic             count_clr,
  output logic             traffic_A,
  output logic             traffic_B,
  output logic [CNT_W-1:0] count_A,
  output logic [CNT_W-1:0] count_B
);
  localparam int NUM_CH = 2;   // bit 0 = A, bit 1 = B

  logic [NUM_CH-1:0]            w_raw;
  logic [NUM_CH-1:0]            w_traffic;
  logic [NUM_CH-1:0]            w_qualify;
  logic [NUM_CH-1:0][CNT_W-1:0] w_count;

  assign w_raw = {raw_B, raw_A};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tsc_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (w_raw[g]),
      .o_traffic(w_traffic[g]),
      .o_qualify(w_qualify[g])
    );

`ifdef TRAFFIC_COUNT_EN
    logic [CNT_W-1:0] r_count;
    // Clear beats a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
      if (reset || count_clr)
        r_count <= '0;
      else if (w_qualify[g] && (r_count != {CNT_W{1'b1}}))
        r_count <= r_count + CNT_W'(1);
    end
    assign w_count[g] = r_count;
`else
    assign w_count[g] = '0;
`endif
  end

`ifndef TRAFFIC_COUNT_EN
  // Counter controls have no load when counting is compiled out.
  logic w_unused_cnt;
  assign w_unused_cnt = ^{count_clr, w_qualify};
`endif

  assign traffic_A = w_traffic[0];
  assign traffic_B = w_traffic[1];
  assign count_A   = w_count[0];
  assign count_B   = w_count[1];
endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
module tb_traffic_sensor_conditioner;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_A = 1'b0, raw_B = 1'b0, count_clr = 1'b0;
  logic       traffic_A, traffic_B;
  logic [1:0] count_A, count_B;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .raw_A(raw_A), .raw_B(raw_B),
    .count_clr(count_clr), .traffic_A(traffic_A), .traffic_B(traffic_B),
    .count_A(count_A), .count_B(count_B)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] v;     // {traffic_A, traffic_B, count_A, count_B}
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [1:0] cv(int n);
    cv = (n > 3) ? 2'd3 : 2'(n);
`ifndef TRAFFIC_COUNT_EN
    cv = 2'd0;
`endif
  endfunction

  task automatic expect_win(int from, int to, string tag,
                            logic ta, logic tb, int ca, int cb);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc = c;
      e.tag = tag;
      e.v   = {ta, tb, cv(ca), cv(cb)};
      sb.push_back(e);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [5:0] obs;
    #2;
    obs = {traffic_A, traffic_B, count_A, count_B};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= edge_cnt) begin
        checks++;
        assert (obs === sb[i].v) else begin
          errors++;
          $error("FAIL %s edge=%0d observed=%b expected=%b {tA,tB,cA,cB}",
                 sb[i].tag, edge_cnt, obs, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    tick(2);
    reset = 1'b0;
    e = edge_cnt;
    expect_win(e, e + 20, "reset_idle", 0, 0, 0, 0);
    tick(20);
    checks++;
    if (traffic_A !== 1'b0) begin
      errors++;
      $display("FAIL idle_direct: traffic_A=%b", traffic_A);
    end
    checks++;
    if (traffic_B !== 1'b0) begin
      errors++;
      $display("FAIL idle_direct: traffic_B=%b", traffic_B);
    end

    e = edge_cnt;
    raw_A = 1'b1;
    expect_win(e + 1, e + 5, "rst_pre", 0, 0, 0, 0);
    expect_win(e + 6, e + 8, "rst_present", 1, 0, 1, 0);
    tick(8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    raw_A = 1'b0;
    expect_win(e + 9, e + 15, "rst_mid", 0, 0, 0, 0);
    tick(6);

    e = edge_cnt;
    expect_win(e, e + 16, "bounce", 0, 0, 0, 0);
    raw_A = 1'b1; tick(3);
    raw_A = 1'b0; tick(1);
    raw_A = 1'b1; tick(3);
    raw_A = 1'b0; tick(10);

    e = edge_cnt;
    raw_A = 1'b1;
    expect_win(e, e + 5, "qual_pre", 0, 0, 0, 0);
    expect_win(e + 6, e + 20, "qual_on", 1, 0, 1, 0);
    tick(20);

    e = edge_cnt;
    raw_A = 1'b0;
    expect_win(e + 1, e + 20, "gap5", 1, 0, 1, 0);
    tick(5);
    raw_A = 1'b1;
    tick(15);

    e = edge_cnt;
    raw_A = 1'b0;
    expect_win(e + 1, e + 10, "fall_hold", 1, 0, 1, 0);
    expect_win(e + 11, e + 17, "fall_off", 0, 0, 1, 0);
    expect_win(e + 18, e + 20, "requal", 1, 0, 2, 0);
    tick(12);
    raw_A = 1'b1;
    tick(8);
    e = edge_cnt;
    raw_A = 1'b0;
    expect_win(e + 1, e + 10, "a_release", 1, 0, 2, 0);
    expect_win(e + 11, e + 12, "a_idle", 0, 0, 2, 0);
    tick(12);

    for (int k = 1; k <= 5; k++) begin
      e = edge_cnt;
      raw_B = 1'b1;
      expect_win(e, e + 5, "satB_pre", 0, 0, 2, k - 1);
      expect_win(e + 6, e + 8, "satB_on", 0, 1, 2, k);
      tick(8);
      raw_B = 1'b0;
      expect_win(e + 9, e + 18, "satB_hold", 0, 1, 2, k);
      expect_win(e + 19, e + 21, "satB_off", 0, 0, 2, k);
      tick(14);
    end

    e = edge_cnt;
    raw_B = 1'b1;
    expect_win(e, e + 5, "clr_pre", 0, 0, 2, 3);
    expect_win(e + 6, e + 8, "clr_win", 0, 1, 0, 0);
    tick(5);
    count_clr = 1'b1;
    tick(1);
    count_clr = 1'b0;
    tick(2);
    raw_B = 1'b0;
    expect_win(e + 9, e + 18, "clr_hold", 0, 1, 0, 0);
    expect_win(e + 19, e + 21, "clr_off", 0, 0, 0, 0);
    tick(14);

    e = edge_cnt;
    raw_A = 1'b1;
    raw_B = 1'b1;
    expect_win(e, e + 5, "both_pre", 0, 0, 0, 0);
    expect_win(e + 6, e + 8, "both_on", 1, 1, 1, 1);
    tick(8);
    raw_A = 1'b0;
    raw_B = 1'b0;
    expect_win(e + 9, e + 18, "both_hold", 1, 1, 1, 1);
    expect_win(e + 19, e + 21, "both_off", 0, 0, 1, 1);
    tick(14);

    tick(2);
    checks++;
    if (traffic_A !== 1'b0 || traffic_B !== 1'b0) begin
      errors++;
      $display("FAIL end_direct: traffic_A=%b traffic_B=%b", traffic_A, traffic_B);
    end
    checks++;
    if (count_A !== cv(1)) begin
      errors++;
      $display("FAIL end_direct: count_A=%0d expected=%0d", count_A, cv(1));
    end
    checks++;
    if (count_B !== cv(1)) begin
      errors++;
      $display("FAIL end_direct: count_B=%0d expected=%0d", count_B, cv(1));
    end
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s expired: due edge=%0d now=%0d", sb[0].tag, sb[0].cyc, edge_cnt);
      void'(sb.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
